rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Write-side counterpart of the pattern ROMs. Takes the HPS download byte stream
//  (ioctl-style) and packs it into DW-wide words. Issues one write per word into the
//  write port of the dual-port pattern RAM that the video side reads.
//  Provides back-pressure to the HPS and a sticky "loaded" status for the pattern selector.
// PARAMETERS
//  AW   16  word-address width of target RAM (depth 2**AW words)
//  DW   8   RAM word width in bits; multiple of 8, range 8..64; BPW = DW/8 bytes per word
// PORTS
//  clock     in   1   system clock
//  reset     in   1   asynchronous, active-high reset
//  dl_en     in   1   download active (level, frames one file)
//  dl_wr     in   1   byte strobe, one cycle per byte; valid only while dl_en=1
//  dl_data   in   8   download byte
//  dl_wait   out  1   back-pressure to HPS; no dl_wr may be issued while high
//  wr_ready  in   1   RAM write port accepts a write this cycle
//  wr_en     out  1   write request; holds until wr_ready
//  wr_addr   out  AW  word address
//  wr_data   out  DW  packed word
//  loaded    out  1   sticky: last download completed without overflow
//  overflow  out  1   sticky: data past 2**AW words, or a byte received during dl_wait
//  done      out  1   one-cycle pulse at end of download
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; byte count 0; word index 0.
//  - Reset mid-download aborts immediately. No further writes. loaded=0.
//  - States: IDLE -> LOAD on dl_en 0->1. On entry, clear word index, byte lane, loaded and overflow.
//  - LOAD: each dl_wr places dl_data in lane k, bits [8k+7:8k], little-endian; the first byte goes to [7:0].
//  - LOAD: when lane BPW-1 is filled, latch word/addr and go to WRITE the next cycle.
//  - WRITE: wr_en=1 with stable wr_addr/wr_data. The write completes in the cycle wr_en&wr_ready.
//    Then the word index increments and the state returns to LOAD, or to FLUSH/DONE if dl_en already fell.
//  - dl_wait=1 in WRITE, FLUSH and DONE. It is asserted combinationally the same cycle the word is latched.
//  - Minimum cost is 1 cycle per word at wr_ready=1 (wr_en for 1 cycle).
//  - dl_wr while dl_wait=1: byte is dropped, overflow<=1.
//  - dl_en falls in LOAD with a partial word (lane>0): go to FLUSH. Unfilled lanes are 0.
//    FLUSH writes like WRITE, then goes to DONE. With lane==0, go straight to DONE.
//  - DONE: done=1 for one cycle; loaded<=~overflow; then IDLE.
//  - Word index reaches 2**AW (wrap boundary): the word is not written (wr_en stays 0).
//    overflow<=1. Later bytes are consumed and discarded. The index does not wrap.
//  - dl_wr and a dl_en fall in the same cycle: the byte is accepted, then the end-of-download path runs.
//  - dl_en re-rising before IDLE is ignored until IDLE is reached.
// CONFIGURATION
//  ROM_LOADER_CSUM_EN defined: adds output csum[7:0], the mod-256 sum of all accepted bytes.
//   csum is cleared on IDLE->LOAD and is valid when done pulses. Dropped bytes are excluded.
//  ROM_LOADER_CSUM_EN undefined: no csum port and no adder logic.
// STRUCTURE
//  Package pattern_pkg: state enum {IDLE,LOAD,WRITE,FLUSH,DONE}, localparam BPW=DW/8,
//   and an elaboration check that DW%8==0 and 8<=DW<=64.
//  One sub-module, byte_packer (parameters DW): lane counter, shift/insert into the word
//   register, outputs full and partial, clear input. FSM, addressing and status stay in rom_loader.
// TESTING
//  1 DW=8,AW=4: dl_en, bytes 11,22,33, wr_ready=1 -> writes (0,11),(1,22),(2,33); done pulse;
//    loaded=1, overflow=0.
//  2 DW=32: bytes 01..06 then dl_en falls -> (0,0x04030201),(1,0x00000605); done; loaded=1.
//  3 DW=16: wr_ready=0 for 5 cycles on the first word -> wr_en and dl_wait held 5 cycles,
//    addr/data stable; write on the 6th.
//  4 DW=8,AW=2: 5 bytes -> 4 writes, 5th dropped; overflow=1; loaded=0 after done.
//  5 reset asserted mid-word in LOAD (2 of 4 bytes) -> all outputs 0 same cycle; no write follows;
//    a new download starts at addr 0.
//  6 with ROM_LOADER_CSUM_EN: bytes FF,02,10 -> csum=0x11 at done; a byte sent during dl_wait
//    is excluded and sets overflow.

Source files
------------

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared state encoding and word-geometry helpers for rom_loader
package pattern_pkg;

  // Loader FSM states (plain constants so older tools and waveform viewers decode them identically)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Bytes packed into one RAM word of width dw
  function automatic int bpw_of(input int dw);
    return dw / 8;
  endfunction

  // Legal RAM word widths: whole bytes, one to eight of them
  function automatic bit dw_valid(input int dw);
    return ((dw % 8) == 0) && (dw >= 8) && (dw <= 64);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte lane packer feeding the rom_loader word register
module byte_packer
  import pattern_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_insert,
  input  logic [7:0]    i_byte,
  output logic [DW-1:0] o_word,
  output logic [DW-1:0] o_ins_word,
  output logic          o_full,
  output logic          o_partial
);

  localparam int BPW = bpw_of(DW);
  localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LW-1:0] r_lane;
  logic [DW-1:0] r_word;

  // Word as it would look with i_byte dropped into the current lane
  always_comb begin
    o_ins_word = r_word;
    for (int k = 0; k < BPW; k++) begin
      if (r_lane == LW'(k)) begin
        o_ins_word[8*k +: 8] = i_byte;
      end
    end
  end

  assign o_word    = r_word;
  assign o_full    = (r_lane == LW'(BPW - 1));
  assign o_partial = (r_lane != '0);

  // Lane counter and accumulated word; a completed word empties the packer so unfilled lanes read 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_insert) begin
      if (o_full) begin
        r_lane <= '0;
        r_word <= '0;
      end else begin
        r_lane <= r_lane + 1'b1;
        r_word <= o_ins_word;
      end
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - HPS download stream to pattern RAM word writer (optional csum via ROM_LOADER_CSUM_EN)
module rom_loader
  import pattern_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dl_en,
  input  logic          dl_wr,
  input  logic [7:0]    dl_data,
  output logic          dl_wait,
  input  logic          wr_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          loaded,
  output logic          overflow,
`ifdef ROM_LOADER_CSUM_EN
  output logic [7:0]    csum,
`endif
  output logic          done
);

  if (!dw_valid(DW) || (AW < 1)) begin : g_bad_cfg
    $error("rom_loader: DW must be a multiple of 8 in 8..64 and AW must be at least 1");
  end

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic          r_dl_en_q;
  logic [AW:0]   r_word_idx;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_loaded;
  logic          r_overflow;

  logic          w_start;
  logic          w_in_load;
  logic          w_busy;
  logic          w_at_end;
  logic          w_take;
  logic          w_discard;
  logic          w_drop;
  logic          w_latch_full;
  logic          w_latch_part;
  logic          w_latch;
  logic          w_fire;
  logic [DW-1:0] w_word;
  logic [DW-1:0] w_ins_word;
  logic          w_full;
  logic          w_partial;

  // A new file starts only on a rising dl_en seen from IDLE; re-rises during the tail are ignored
  assign w_start   = (r_state == ST_IDLE) && dl_en && !r_dl_en_q;
  assign w_in_load = (r_state == ST_LOAD);
  assign w_busy    = (r_state == ST_WRITE) || (r_state == ST_FLUSH) || (r_state == ST_DONE);

  // Index one past the last RAM word: everything after this is thrown away
  assign w_at_end  = r_word_idx[AW];

  assign w_take    = w_in_load && dl_wr && !w_at_end;
  assign w_discard = w_in_load && dl_wr && w_at_end;
  assign w_drop    = dl_wr && w_busy;

  // Full word completes this cycle, or dl_en fell leaving a partly filled word behind
  assign w_latch_full = w_take && w_full;
  assign w_latch_part = w_in_load && !dl_en && !w_latch_full && (w_take || w_partial);
  assign w_latch      = w_latch_full || w_latch_part;

  assign wr_en  = (r_state == ST_WRITE) || (r_state == ST_FLUSH);
  assign w_fire = wr_en && wr_ready;

  // Back-pressure comes up in the very cycle the last lane is filled so the HPS holds off immediately
  assign dl_wait = w_busy || w_latch_full;

  byte_packer #(
    .DW (DW)
  ) u_packer (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_start || w_latch),
    .i_insert   (w_take),
    .i_byte     (dl_data),
    .o_word     (w_word),
    .o_ins_word (w_ins_word),
    .o_full     (w_full),
    .o_partial  (w_partial)
  );

  // Next-state selection for the download sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_latch_full)      w_next_state = ST_WRITE;
        else if (w_latch_part) w_next_state = ST_FLUSH;
        else if (!dl_en)       w_next_state = ST_DONE;
      end
      ST_WRITE: begin
        if (w_fire) w_next_state = dl_en ? ST_LOAD : ST_DONE;
      end
      ST_FLUSH: begin
        if (w_fire) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, word index, pending write and sticky status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_dl_en_q  <= 1'b0;
      r_word_idx <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_loaded   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_dl_en_q <= dl_en;
      if (w_start) begin
        r_word_idx <= '0;
        r_loaded   <= 1'b0;
        r_overflow <= 1'b0;
      end
      if (w_latch) begin
        r_wr_addr <= r_word_idx[AW-1:0];
        r_wr_data <= w_take ? w_ins_word : w_word;
      end
      if (w_fire) begin
        r_word_idx <= r_word_idx + 1'b1;
      end
      if (w_drop || w_discard) begin
        r_overflow <= 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_loaded <= !(r_overflow || w_drop);
      end
    end
  end

`ifdef ROM_LOADER_CSUM_EN
  logic [7:0] r_csum;

  // Running mod-256 sum over bytes that actually land in a word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_take) begin
      r_csum <= r_csum + dl_data;
    end
  end

  assign csum = r_csum;
`endif

  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign loaded   = r_loaded;
  assign overflow = r_overflow;
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - self-checking bench for rom_loader (DW=32, AW=2) against a byte-list reference model
module tb_rom_loader;

  localparam int AW   = 2;
  localparam int DW   = 32;
  localparam int BPW  = DW / 8;
  localparam int MAXB = (1 << AW) * BPW;

  typedef logic [7:0] byte_q_t[$];

  logic          clock = 1'b0;
  logic          reset;
  logic          dl_en;
  logic          dl_wr;
  logic [7:0]    dl_data;
  logic          dl_wait;
  logic          wr_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          loaded;
  logic          overflow;
  logic          done;
`ifdef ROM_LOADER_CSUM_EN
  logic [7:0]    csum;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            done_cnt   = 0;
  int            wen_cycles = 0;

  bit            rdy_force = 1'b0;
  bit            rdy_val   = 1'b0;
  int            rdy_pct   = 100;

  rom_loader #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .dl_en    (dl_en),
    .dl_wr    (dl_wr),
    .dl_data  (dl_data),
    .dl_wait  (dl_wait),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .loaded   (loaded),
    .overflow (overflow),
`ifdef ROM_LOADER_CSUM_EN
    .csum     (csum),
`endif
    .done     (done)
  );

  always #5 clock = ~clock;

  // RAM-side readiness: forced level or random acceptance, changed just after the rising edge
  always @(posedge clock) begin
    #2;
    wr_ready = rdy_force ? rdy_val : ($urandom_range(0, 99) < rdy_pct);
  end

  // Observe completed writes and done pulses on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_en) wen_cycles++;
      if (wr_en && wr_ready) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit fall);
    int n = 0;
    while (dl_wait && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_byte_wait: dl_wait=%b still high after %0d cycles, expected 0", dl_wait, n);
    end
    dl_data = b;
    dl_wr   = 1'b1;
    if (fall) dl_en = 1'b0;
    @(negedge clock);
    dl_wr = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clock); #1;
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_done_timeout: no done pulse in %0d cycles, expected one", name, n);
    end
    repeat (2) @(negedge clock);
    #1;
  endtask

  // Full download of a byte list, checked against words/status derived from the list itself
  task automatic test_download(input string name, input byte_q_t bytes, input bit fall_with_last);
    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] acc;
    logic [7:0]    exp_sum;
    bit            exp_ovf;
    int            nacc;
    int            wbase;
    int            d0;

    nacc    = (bytes.size() > MAXB) ? MAXB : bytes.size();
    exp_ovf = (bytes.size() > MAXB);
    exp_sum = 8'h00;
    acc     = '0;
    for (int i = 0; i < nacc; i++) begin
      acc     = acc | (DW'(bytes[i]) << (8 * (i % BPW)));
      exp_sum = exp_sum + bytes[i];
      if ((i % BPW) == BPW - 1 || i == nacc - 1) begin
        exp_w.push_back(acc);
        acc = '0;
      end
    end

    wbase = wa_q.size();
    d0    = done_cnt;
    dl_en = 1'b1;
    @(negedge clock); #1;
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], fall_with_last && (i == bytes.size() - 1));
    end
    dl_en = 1'b0;
    wait_done(d0, name);

    checks++;
    if (wa_q.size() - wbase !== exp_w.size()) begin
      errors++;
      $display("FAIL %s_nwrites: got %0d writes, expected %0d", name, wa_q.size() - wbase, exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && (wbase + i) < wa_q.size(); i++) begin
      checks++;
      if (wa_q[wbase+i] !== AW'(i) || wd_q[wbase+i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got addr %0d data %h, expected addr %0d data %h",
                 name, i, wa_q[wbase+i], wd_q[wbase+i], i, exp_w[i]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d pulses, expected 1", name, done_cnt - d0);
    end
    checks++;
    if (overflow !== exp_ovf || loaded !== !exp_ovf) begin
      errors++;
      $display("FAIL %s_status: got overflow=%b loaded=%b, expected overflow=%b loaded=%b",
               name, overflow, loaded, exp_ovf, !exp_ovf);
    end
`ifdef ROM_LOADER_CSUM_EN
    checks++;
    if (csum !== exp_sum) begin
      errors++;
      $display("FAIL %s_csum: got %h, expected %h", name, csum, exp_sum);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({wr_en, dl_wait, done, loaded, overflow} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr_en=%b dl_wait=%b done=%b loaded=%b overflow=%b addr=%h data=%h, expected all 0",
               wr_en, dl_wait, done, loaded, overflow, wr_addr, wr_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({wr_en, dl_wait, done, loaded} !== 4'b0) begin
      errors++;
      $display("FAIL idle_outputs: got wr_en=%b dl_wait=%b done=%b loaded=%b, expected all 0",
               wr_en, dl_wait, done, loaded);
    end
  endtask

  task automatic test_basic();
    byte_q_t bq;
    rdy_force = 1'b0;
    rdy_pct   = 100;
    bq = {};
    bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
    test_download("partial3", bq, 1'b0);
    bq = {};
    for (int i = 1; i <= 6; i++) bq.push_back(8'(i));
    test_download("two_words", bq, 1'b0);
    bq = {};
    bq.push_back(8'hFF); bq.push_back(8'h02); bq.push_back(8'h10);
    test_download("fall_with_byte", bq, 1'b1);
    bq = {};
    test_download("empty", bq, 1'b0);
  endtask

  task automatic test_stall();
    int wbase;
    int w0;
    int d0;
    wbase     = wa_q.size();
    w0        = wen_cycles;
    d0        = done_cnt;
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    dl_en     = 1'b1;
    @(negedge clock); #1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    dl_data = 8'h44;
    dl_wr   = 1'b1;
    #1;
    checks++;
    if (dl_wait !== 1'b1) begin
      errors++;
      $display("FAIL stall_wait_comb: got dl_wait=%b on last-lane byte, expected 1", dl_wait);
    end
    @(negedge clock);
    dl_wr = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_en !== 1'b1 || dl_wait !== 1'b1 || wr_addr !== '0 || wr_data !== 32'h44332211) begin
        errors++;
        $display("FAIL stall_hold%0d: got wr_en=%b dl_wait=%b addr=%h data=%h, expected 1 1 0 44332211",
                 i, wr_en, dl_wait, wr_addr, wr_data);
      end
      if (i < 4) begin
        @(negedge clock); #1;
      end
    end
    checks++;
    if (wa_q.size() !== wbase) begin
      errors++;
      $display("FAIL stall_early_write: got %0d writes while stalled, expected 0", wa_q.size() - wbase);
    end
    rdy_val = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (wa_q.size() - wbase !== 1 || wen_cycles - w0 !== 6) begin
      errors++;
      $display("FAIL stall_release: got %0d writes over %0d wr_en cycles, expected 1 over 6",
               wa_q.size() - wbase, wen_cycles - w0);
    end
    dl_en     = 1'b0;
    rdy_force = 1'b0;
    wait_done(d0, "stall");
    checks++;
    if (loaded !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL stall_status: got loaded=%b overflow=%b, expected 1 0", loaded, overflow);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t bq;
    int wbase;
    int d0;
    wbase = wa_q.size();
    d0    = done_cnt;
    dl_en = 1'b1;
    @(negedge clock); #1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    #2;
    reset = 1'b1;
    dl_en = 1'b0;
    #1;
    checks++;
    if ({wr_en, dl_wait, done, loaded, overflow} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got wr_en=%b dl_wait=%b done=%b loaded=%b overflow=%b addr=%h data=%h, expected all 0",
               wr_en, dl_wait, done, loaded, overflow, wr_addr, wr_data);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (wa_q.size() !== wbase || done_cnt !== d0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d writes %0d dones after abort, expected 0 0",
               wa_q.size() - wbase, done_cnt - d0);
    end
    bq = {};
    bq.push_back(8'h5A); bq.push_back(8'hC3); bq.push_back(8'h0F); bq.push_back(8'hE1); bq.push_back(8'h77);
    test_download("after_reset", bq, 1'b0);
  endtask

  task automatic test_overflow();
    byte_q_t bq;
    rdy_pct = 60;
    bq = {};
    for (int i = 0; i < MAXB; i++) bq.push_back(8'($urandom));
    test_download("exact_fill", bq, 1'b0);
    bq.push_back(8'h99);
    test_download("past_end", bq, 1'b0);
    rdy_pct = 100;
  endtask

  task automatic test_drop();
    int wbase;
    int d0;
    wbase     = wa_q.size();
    d0        = done_cnt;
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    dl_en     = 1'b1;
    @(negedge clock); #1;
    send_byte(8'hFF, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    dl_data = 8'h77;
    dl_wr   = 1'b1;
    @(negedge clock);
    dl_wr = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_overflow: got overflow=%b after byte under dl_wait, expected 1", overflow);
    end
    rdy_force = 1'b0;
    dl_en     = 1'b0;
    wait_done(d0, "drop");
    checks++;
    if (wa_q.size() - wbase !== 1 || (wa_q.size() > wbase && wd_q[wbase] !== 32'h201002FF)) begin
      errors++;
      $display("FAIL drop_write: got %0d writes first data %h, expected 1 write of 201002ff",
               wa_q.size() - wbase, (wa_q.size() > wbase) ? wd_q[wbase] : 32'h0);
    end
    checks++;
    if (loaded !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_status: got loaded=%b overflow=%b, expected 0 1", loaded, overflow);
    end
`ifdef ROM_LOADER_CSUM_EN
    checks++;
    if (csum !== 8'h31) begin
      errors++;
      $display("FAIL drop_csum: got %h, expected 31", csum);
    end
`endif
  endtask

  task automatic test_random();
    byte_q_t bq;
    int      len;
    for (int t = 0; t < 8; t++) begin
      rdy_pct = $urandom_range(30, 100);
      len     = $urandom_range(0, MAXB + 2);
      bq = {};
      for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
      test_download($sformatf("rand%0d", t), bq, (len > 0) && $urandom_range(0, 1) == 1);
    end
    rdy_pct = 100;
  endtask

  initial begin
    reset   = 1'b1;
    dl_en   = 1'b0;
    dl_wr   = 1'b0;
    dl_data = 8'h00;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_overflow();
    test_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
